// File: rtl/big_core_wb_stage.sv
// Q105H write-back stage: selects write-back data, aligns load data, issues the RF write and stalls on loads.
// Optional macro BIG_CORE_WB_RSP_TIMEOUT_EN adds a response timeout with a RspTimeout pulse output.
module big_core_wb_stage #(
   parameter int RETIRE_CNT_W = 64,
   parameter int RSP_TIMEOUT  = 255
) (
   input  logic                    Clock,
   input  logic                    Rst,
   input  logic                    ValidQ105H,
   input  logic [31:0]             PcPlus4Q105H,
   input  logic [31:0]             AluOutQ105H,
   input  logic [1:0]              SelWbQ105H,
   input  logic                    RegWrEnQ105H,
   input  logic [4:0]              RdQ105H,
   input  logic [2:0]              LdFunct3Q105H,
   input  logic                    DMemRspValid,
   input  logic [31:0]             DMemRspData,
   output logic                    ReadyQ105H,
   output logic [31:0]             WbDataQ105H,
   output logic                    RfWrEn,
   output logic [4:0]              RfWrAddr,
   output logic [31:0]             RfWrData,
`ifdef BIG_CORE_WB_RSP_TIMEOUT_EN
   output logic                    RspTimeout,
`endif
   output logic [RETIRE_CNT_W-1:0] RetireCnt
);

   typedef enum logic {RUN, WAIT_RSP} state_t;

   state_t      state;
   logic        is_load;
   logic        commit;
   logic        rf_write;
   logic        timeout_hit;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   assign is_load  = ValidQ105H && (SelWbQ105H == 2'd1);
   assign commit   = ValidQ105H && ReadyQ105H;
   assign rf_write = commit && RegWrEnQ105H && (RdQ105H != 5'd0);

`ifdef BIG_CORE_WB_RSP_TIMEOUT_EN
   logic [7:0] timeout_cnt;

   // The counter holds the number of WAIT_RSP cycles already spent, so the limit hits on the RSP_TIMEOUT-th one.
   assign timeout_hit = (state == WAIT_RSP) && !DMemRspValid && (timeout_cnt == 8'(RSP_TIMEOUT - 1));

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         timeout_cnt <= 8'd0;
         RspTimeout  <= 1'b0;
      end else begin
         RspTimeout <= timeout_hit;
         if (state == RUN)
            timeout_cnt <= 8'd0;
         else
            timeout_cnt <= timeout_cnt + 8'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      ReadyQ105H = 1'b1;
      if (state == RUN)
         ReadyQ105H = !(is_load && !DMemRspValid);
      else
         ReadyQ105H = DMemRspValid || timeout_hit;
   end

   always_comb begin
      byte_sel = DMemRspData[7:0];
      case (AluOutQ105H[1:0])
         2'd1:    byte_sel = DMemRspData[15:8];
         2'd2:    byte_sel = DMemRspData[23:16];
         2'd3:    byte_sel = DMemRspData[31:24];
         default: byte_sel = DMemRspData[7:0];
      endcase
      half_sel = AluOutQ105H[1] ? DMemRspData[31:16] : DMemRspData[15:0];
      load_data = DMemRspData;
      case (LdFunct3Q105H)
         3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
         3'd4:    load_data = {24'd0, byte_sel};
         3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
         3'd5:    load_data = {16'd0, half_sel};
         default: load_data = DMemRspData;
      endcase
   end

   // Reserved select value 3 falls through to the ALU result.
   always_comb begin
      WbDataQ105H = AluOutQ105H;
      case (SelWbQ105H)
         2'd1:    WbDataQ105H = timeout_hit ? 32'hDEAD_BEEF : load_data;
         2'd2:    WbDataQ105H = PcPlus4Q105H;
         default: WbDataQ105H = AluOutQ105H;
      endcase
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state     <= RUN;
         RfWrEn    <= 1'b0;
         RfWrAddr  <= 5'd0;
         RfWrData  <= 32'd0;
         RetireCnt <= '0;
      end else begin
         case (state)
            RUN:      if (is_load && !DMemRspValid) state <= WAIT_RSP;
            WAIT_RSP: if (DMemRspValid || timeout_hit) state <= RUN;
            default:  state <= RUN;
         endcase
         RfWrEn <= rf_write;
         if (rf_write) begin
            RfWrAddr <= RdQ105H;
            RfWrData <= WbDataQ105H;
         end
         if (commit)
            RetireCnt <= RetireCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_big_core_wb_stage.sv
// Scoreboard bench for big_core_wb_stage: expected RF writes are queued at issue and popped when RfWrEn fires.
module tb_big_core_wb_stage;

`ifdef BIG_CORE_WB_RSP_TIMEOUT_EN
   localparam int RSP_TO = 4;
`else
   localparam int RSP_TO = 255;
`endif

   logic        Clock = 1'b0;
   logic        Rst;
   logic        ValidQ105H;
   logic [31:0] PcPlus4Q105H;
   logic [31:0] AluOutQ105H;
   logic [1:0]  SelWbQ105H;
   logic        RegWrEnQ105H;
   logic [4:0]  RdQ105H;
   logic [2:0]  LdFunct3Q105H;
   logic        DMemRspValid;
   logic [31:0] DMemRspData;
   logic        ReadyQ105H;
   logic [31:0] WbDataQ105H;
   logic        RfWrEn;
   logic [4:0]  RfWrAddr;
   logic [31:0] RfWrData;
   logic [63:0] RetireCnt;
`ifdef BIG_CORE_WB_RSP_TIMEOUT_EN
   logic        RspTimeout;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [63:0] expRetire = 0;
   logic [36:0] expQ[$];

   big_core_wb_stage #(.RETIRE_CNT_W(64), .RSP_TIMEOUT(RSP_TO)) dut (
      .Clock(Clock), .Rst(Rst), .ValidQ105H(ValidQ105H), .PcPlus4Q105H(PcPlus4Q105H),
      .AluOutQ105H(AluOutQ105H), .SelWbQ105H(SelWbQ105H), .RegWrEnQ105H(RegWrEnQ105H),
      .RdQ105H(RdQ105H), .LdFunct3Q105H(LdFunct3Q105H), .DMemRspValid(DMemRspValid),
      .DMemRspData(DMemRspData), .ReadyQ105H(ReadyQ105H), .WbDataQ105H(WbDataQ105H),
      .RfWrEn(RfWrEn), .RfWrAddr(RfWrAddr), .RfWrData(RfWrData),
`ifdef BIG_CORE_WB_RSP_TIMEOUT_EN
      .RspTimeout(RspTimeout),
`endif
      .RetireCnt(RetireCnt)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Every RF write is matched against the oldest queued expectation.
   always @(posedge Clock) begin
      #1;
      if (Rst && RfWrEn) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_wr", 64'(RfWrEn), 64'd0);
         end else begin
            logic [36:0] e;
            e = expQ.pop_front();
            checkOutput("wr_addr", 64'(RfWrAddr), 64'(e[36:32]));
            checkOutput("wr_data", 64'(RfWrData), 64'(e[31:0]));
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [4:0] rd, input logic regwr,
                                input int rspDelay, input logic [31:0] rspData, input logic [31:0] expData);
      @(negedge Clock);
      ValidQ105H    = 1'b1;
      SelWbQ105H    = sel;
      LdFunct3Q105H = f3;
      AluOutQ105H   = alu;
      PcPlus4Q105H  = pc4;
      RdQ105H       = rd;
      RegWrEnQ105H  = regwr;
      DMemRspData   = rspData;
      DMemRspValid  = (sel == 2'd1) && (rspDelay == 0);
      if (regwr && rd != 5'd0) expQ.push_back({rd, expData});
      expRetire++;
      for (int i = 0; i < rspDelay; i++) begin
         #1 checkOutput("ready_stall", 64'(ReadyQ105H), 64'd0);
         @(negedge Clock);
         if (i == rspDelay - 1) DMemRspValid = 1'b1;
      end
      #1;
      checkOutput("ready_go", 64'(ReadyQ105H), 64'd1);
      checkOutput("wb_data", 64'(WbDataQ105H), 64'(expData));
      @(negedge Clock);
      ValidQ105H   = 1'b0;
      DMemRspValid = 1'b0;
      checkOutput("retire", RetireCnt, expRetire);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Rst = 1'b0; ValidQ105H = 0; PcPlus4Q105H = 0; AluOutQ105H = 0; SelWbQ105H = 0;
      RegWrEnQ105H = 0; RdQ105H = 0; LdFunct3Q105H = 0; DMemRspValid = 0; DMemRspData = 0;
      repeat (2) @(negedge Clock);
      checkOutput("rst_wren", 64'(RfWrEn), 64'd0);
      checkOutput("rst_addr", 64'(RfWrAddr), 64'd0);
      checkOutput("rst_data", 64'(RfWrData), 64'd0);
      checkOutput("rst_retire", RetireCnt, 64'd0);
      checkOutput("rst_ready", 64'(ReadyQ105H), 64'd1);
      Rst = 1'b1;

      applyStimulus(2'd0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0, 32'h1234);
      applyStimulus(2'd2, 3'd0, 32'h55, 32'h104, 5'd1, 1'b1, 0, 32'h0, 32'h104);
      applyStimulus(2'd2, 3'd0, 32'h55, 32'h208, 5'd0, 1'b1, 0, 32'h0, 32'h208);
      checkOutput("hold_addr", 64'(RfWrAddr), 64'd1);
      checkOutput("hold_data", 64'(RfWrData), 64'h104);
      applyStimulus(2'd3, 3'd0, 32'hABCD, 32'h300, 5'd7, 1'b1, 0, 32'h0, 32'hABCD);
      applyStimulus(2'd0, 3'd0, 32'h99, 32'h0, 5'd8, 1'b0, 0, 32'h0, 32'h99);
      applyStimulus(2'd1, 3'd0, 32'h1003, 32'h0, 5'd10, 1'b1, 3, 32'h80FF_FF7F, 32'hFFFF_FF80);
      applyStimulus(2'd1, 3'd4, 32'h1003, 32'h0, 5'd11, 1'b1, 3, 32'h80FF_FF7F, 32'h0000_0080);
      applyStimulus(2'd1, 3'd1, 32'h1002, 32'h0, 5'd12, 1'b1, 0, 32'h8001_1234, 32'hFFFF_8001);
      applyStimulus(2'd1, 3'd5, 32'h1001, 32'h0, 5'd13, 1'b1, 0, 32'h8001_1234, 32'h0000_1234);
      applyStimulus(2'd1, 3'd0, 32'h1001, 32'h0, 5'd14, 1'b1, 1, 32'h0000_9A00, 32'hFFFF_FF9A);
      applyStimulus(2'd1, 3'd2, 32'h1000, 32'h0, 5'd15, 1'b1, 2, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Stranded load: reset while waiting, then a late response must be ignored.
      @(negedge Clock);
      ValidQ105H = 1'b1; SelWbQ105H = 2'd1; LdFunct3Q105H = 3'd2; RdQ105H = 5'd20; RegWrEnQ105H = 1'b1;
      repeat (2) @(negedge Clock);
      #1 checkOutput("pre_rst_stall", 64'(ReadyQ105H), 64'd0);
      Rst = 1'b0;
      ValidQ105H = 1'b0;
      #1;
      checkOutput("mid_rst_wren", 64'(RfWrEn), 64'd0);
      checkOutput("mid_rst_addr", 64'(RfWrAddr), 64'd0);
      checkOutput("mid_rst_retire", RetireCnt, 64'd0);
      expRetire = 0;
      @(negedge Clock);
      Rst = 1'b1;
      DMemRspValid = 1'b1; DMemRspData = 32'h1111_2222;
      #1 checkOutput("late_rsp_ready", 64'(ReadyQ105H), 64'd1);
      @(negedge Clock);
      DMemRspValid = 1'b0;
      checkOutput("late_rsp_wren", 64'(RfWrEn), 64'd0);
      checkOutput("late_rsp_retire", RetireCnt, 64'd0);
      checkOutput("late_rsp_data", 64'(RfWrData), 64'd0);
      applyStimulus(2'd0, 3'd0, 32'h77, 32'h0, 5'd3, 1'b1, 0, 32'h0, 32'h77);

`ifdef BIG_CORE_WB_RSP_TIMEOUT_EN
      @(negedge Clock);
      ValidQ105H = 1'b1; SelWbQ105H = 2'd1; LdFunct3Q105H = 3'd2; RdQ105H = 5'd9; RegWrEnQ105H = 1'b1;
      expQ.push_back({5'd9, 32'hDEAD_BEEF});
      expRetire++;
      for (int i = 0; i < RSP_TO; i++) begin
         #1 checkOutput("to_stall", 64'(ReadyQ105H), 64'd0);
         @(negedge Clock);
      end
      #1 checkOutput("to_ready", 64'(ReadyQ105H), 64'd1);
      checkOutput("to_wbdata", 64'(WbDataQ105H), 64'hDEAD_BEEF);
      @(negedge Clock);
      ValidQ105H = 1'b0;
      checkOutput("to_pulse", 64'(RspTimeout), 64'd1);
      checkOutput("to_retire", RetireCnt, expRetire);
      @(negedge Clock);
      checkOutput("to_pulse_end", 64'(RspTimeout), 64'd0);
      checkOutput("to_run_ready", 64'(ReadyQ105H), 64'd1);
`endif

      repeat (3) @(negedge Clock);
      checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
